// File: rtl/semaforo_timer_if.sv
// Light/timeout bundle between the traffic-light FSM (master) and its phase timer (slave).
// SEMAFORO_TIMER_FAULT_EN adds the sticky illegal-code fault flag.
interface semaforo_timer_if;
    logic red;
    logic ylw;
    logic grn;
    logic hold;
    logic timeout;
`ifdef SEMAFORO_TIMER_FAULT_EN
    logic fault;

    modport master (output red, ylw, grn, hold, input timeout, fault);
    modport slave  (input red, ylw, grn, hold, output timeout, fault);
`else
    modport master (output red, ylw, grn, hold, input timeout);
    modport slave  (input red, ylw, grn, hold, output timeout);
`endif
endinterface

// File: rtl/semaforo_timer.sv
// Phase timer feeding the traffic-light FSM: reloads on each lamp change and emits one timeout pulse per phase.
// Optional SEMAFORO_TIMER_FAULT_EN adds a sticky fault output for illegal lamp codes.
module semaforo_timer #(
    parameter int unsigned T_GRN = 4,
    parameter int unsigned T_YLW = 2,
    parameter int unsigned T_RED = 5,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    semaforo_timer_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COUNT   = 2'd1;
    localparam logic [1:0] S_EXPIRED = 2'd2;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YLW = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    localparam logic [CNT_W-1:0] RELOAD_GRN = CNT_W'(T_GRN - 1);
    localparam logic [CNT_W-1:0] RELOAD_YLW = CNT_W'(T_YLW - 1);
    localparam logic [CNT_W-1:0] RELOAD_RED = CNT_W'(T_RED - 1);

    logic [2:0]       light_c;
    logic             valid_c;
    logic             change_c;
    logic [CNT_W-1:0] reload_c;

    logic [2:0]       last_l_q, last_l_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic             timeout_q, timeout_d;

    assign light_c  = {bus.red, bus.ylw, bus.grn};
    assign change_c = (light_c != last_l_q);

    // Decode the lamp code into legality and the phase's reload value (duration - 1).
    always_comb begin
        valid_c  = 1'b1;
        reload_c = '0;
        case (light_c)
            L_RED:   reload_c = RELOAD_RED;
            L_YLW:   reload_c = RELOAD_YLW;
            L_GRN:   reload_c = RELOAD_GRN;
            default: valid_c  = 1'b0;
        endcase
    end

    // Next state: a phase change outranks both hold and expiry.
    always_comb begin
        last_l_d  = last_l_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        timeout_d = 1'b0;
        if (change_c) begin
            last_l_d = light_c;
            if (valid_c) begin
                cnt_d   = reload_c;
                state_d = S_COUNT;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_COUNT: begin
                    if (!bus.hold) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            timeout_d = 1'b1;
                            state_d   = S_EXPIRED;
                        end
                    end
                end
                S_IDLE, S_EXPIRED: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_l_q  <= 3'b000;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
            timeout_q <= 1'b0;
        end else begin
            last_l_q  <= last_l_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;

`ifdef SEMAFORO_TIMER_FAULT_EN
    logic fault_q, fault_d;

    // Sticky until reset; any non-one-hot code counts, including all-off.
    always_comb begin
        fault_d = fault_q | ~valid_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign bus.fault = fault_q;
`endif

endmodule

// File: tb/tb_semaforo_timer.sv
// Directed bench for semaforo_timer: default-parameter instance plus a T_YLW=1 instance sharing the same lamps.
module tb_semaforo_timer;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    semaforo_timer_if bus ();
    semaforo_timer_if bus1 ();

    assign bus1.red  = bus.red;
    assign bus1.ylw  = bus.ylw;
    assign bus1.grn  = bus.grn;
    assign bus1.hold = bus.hold;

    semaforo_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    semaforo_timer #(.T_YLW(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Rising edges at 10, 20, 30 ... ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_l(input logic [2:0] l);
        {bus.red, bus.ylw, bus.grn} = l;
    endtask

    // Call right after the detection edge: pulse must appear after exactly n further edges, then drop.
    task automatic expect_pulse(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            tick();
            check($sformatf("%s_c%0d", tag, i), bus.timeout, (i == n));
        end
        tick();
        check($sformatf("%s_drop", tag), bus.timeout, 1'b0);
    endtask

    initial begin
        int highs;
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        bus.hold = 1'b0;
        set_l(3'b001);

        // Reset held for 15 ns with green on the lamps.
        #4;
        check("rst_t4", bus.timeout, 1'b0);
        #8;
        check("rst_t12", bus.timeout, 1'b0);
`ifdef SEMAFORO_TIMER_FAULT_EN
        check("rst_fault", bus.fault, 1'b0);
`endif
        #3;
        rst_n = 1'b1;

        // First green after reset: detection at edge 20, pulse after 4 edges.
        tick();
        check("grn0_det", bus.timeout, 1'b0);
        expect_pulse("grn0", 4);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.timeout) highs++;
        end
        check("grn0_no_repeat", (highs != 0), 1'b0);

        // Yellow and red from an expired green.
        set_l(3'b010);
        tick();
        expect_pulse("ylw1", 2);
        set_l(3'b100);
        tick();
        expect_pulse("red1", 5);

        // Green cut short by yellow two cycles after detection.
        set_l(3'b001);
        tick();
        tick();
        check("grn2_mid", bus.timeout, 1'b0);
        set_l(3'b010);
        tick();
        check("grn2_cut", bus.timeout, 1'b0);
        expect_pulse("ylw2", 2);
        set_l(3'b100);
        tick();
        expect_pulse("red2", 5);

        // Red with hold for 3 cycles mid-count: pulse at 8 edges after detection.
        set_l(3'b001);
        tick();
        set_l(3'b100);
        tick();
        tick();
        tick();
        check("hold_pre", bus.timeout, 1'b0);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_on%0d", i), bus.timeout, 1'b0);
        end
        bus.hold = 1'b0;
        tick();
        check("hold_e6", bus.timeout, 1'b0);
        tick();
        check("hold_e7", bus.timeout, 1'b0);
        tick();
        check("hold_e8", bus.timeout, 1'b1);
        tick();
        check("hold_drop", bus.timeout, 1'b0);

        // Yellow to red on the would-be expiry edge; T_YLW=1 instance pulses normally meanwhile.
        set_l(3'b010);
        tick();
        check("race_det", bus.timeout, 1'b0);
        check("t1_det", bus1.timeout, 1'b0);
        tick();
        check("race_e1", bus.timeout, 1'b0);
        check("t1_pulse", bus1.timeout, 1'b1);
        set_l(3'b100);
        tick();
        check("race_e2", bus.timeout, 1'b0);
        check("t1_drop", bus1.timeout, 1'b0);
        expect_pulse("race_red", 5);

        // Async reset mid-red with cnt=2, then restart with red already on the lamps.
        set_l(3'b001);
        tick();
        set_l(3'b100);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_mid", bus.timeout, 1'b0);
        tick();
        check("arst_held", bus.timeout, 1'b0);
        rst_n = 1'b1;
        tick();
        check("arst_det", bus.timeout, 1'b0);
        expect_pulse("arst_red", 5);

        // Async reset while the pulse is high clears it before the next edge.
        set_l(3'b010);
        tick();
        tick();
        tick();
        check("arst_pulse_hi", bus.timeout, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pulse_lo", bus.timeout, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_pulse("arst_ylw", 2);

        // Illegal code for one cycle forces idle; next green restarts normally.
`ifdef SEMAFORO_TIMER_FAULT_EN
        check("fault_pre", bus.fault, 1'b0);
`endif
        set_l(3'b110);
        tick();
        check("ill_idle", bus.timeout, 1'b0);
`ifdef SEMAFORO_TIMER_FAULT_EN
        check("fault_set", bus.fault, 1'b1);
`endif
        set_l(3'b001);
        tick();
        check("ill_grn_det", bus.timeout, 1'b0);
        expect_pulse("ill_grn", 4);
`ifdef SEMAFORO_TIMER_FAULT_EN
        check("fault_sticky", bus.fault, 1'b1);
`endif

        // Illegal code mid-count cancels the phase: no pulse while it persists.
        set_l(3'b010);
        tick();
        set_l(3'b011);
        highs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.timeout) highs++;
        end
        check("ill_cancel", (highs != 0), 1'b0);

        rst_n = 1'b0;
        #1;
`ifdef SEMAFORO_TIMER_FAULT_EN
        check("fault_clear", bus.fault, 1'b0);
`endif
        check("final_rst", bus.timeout, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/semaforo_timer.md
Name: semaforo_timer

Overview:
- Phase timer that generates the `timeout` input of the traffic-light FSM. It sits directly upstream of the FSM and monitors the FSM's red/ylw/grn outputs.
- On every light-phase change it loads a phase-specific duration and counts down.
- When the count expires it emits a single-cycle `timeout` pulse.
- Exactly one pulse per phase. Counting restarts whenever the phase changes.

Parameters:
- T_GRN, 4, green phase duration in clock cycles (min-green); legal range 1..2^CNT_W
- T_YLW, 2, yellow phase duration in clock cycles; legal range 1..2^CNT_W
- T_RED, 5, red phase duration in clock cycles; legal range 1..2^CNT_W
- CNT_W, 8, countdown register width

Ports:
- Clock  input  1  system clock, rising edge
- Reset  input  1  asynchronous active-low reset (0 = reset asserted)
- red    input  1  red lamp from FSM
- ylw    input  1  yellow lamp from FSM
- grn    input  1  green lamp from FSM
- hold   input  1  1 = freeze countdown (maintenance/emergency)
- timeout  output  1  registered, one-cycle pulse on phase expiry

Behaviour:
- Light code L = {red,ylw,grn}, sampled each rising edge. Valid codes: 100, 010, 001. Any other code is illegal.
- Registers:
  - last_L: 3 bits
  - cnt: CNT_W bits
  - state: IDLE / COUNT / EXPIRED
  - timeout
- Reset (Reset=0, async): last_L=000, cnt=0, state=IDLE, timeout=0. Takes effect immediately, mid-count included. No pulse is emitted on release.
- Phase change: L != last_L at an edge.
  - Always sets last_L<=L.
  - If L is valid: cnt<=T(L)-1, state<=COUNT, timeout<=0.
  - If L is illegal: state<=IDLE, timeout<=0.
  - After reset, the first valid L counts as a phase change, because last_L=000.
- COUNT, no phase change, hold=0:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: timeout<=1, state<=EXPIRED.
- COUNT with hold=1: cnt and state are frozen and timeout<=0. A phase change still reloads, because reload has priority over hold.
- EXPIRED: timeout<=0 and the block waits for a phase change. No second pulse is emitted in the same phase.
- IDLE: timeout<=0 and the block waits for a valid phase change.
- Latency: with detection at edge E0 and no hold, timeout is high in the cycle following edge E0+T(L), i.e. exactly T(L) cycles after detection. With T=1, timeout rises at E0+1.
- Each cycle of hold=1 during COUNT extends the latency by one cycle.
- Simultaneous phase change and expiry on the same edge: the reload wins and no timeout is emitted.
- Phase change while timeout=1: timeout drops on the next edge, as in the normal case, and the new count starts.
- Pulse width is exactly 1 cycle in all cases.

Optional Feature:
- Macro: SEMAFORO_TIMER_FAULT_EN.
- When defined:
  - Adds output port `fault` (1 bit, registered).
  - fault<=1 at any edge where L is illegal, and stays sticky until Reset=0.
  - fault does not alter the counting rules above.
- When undefined: the `fault` port is absent. Illegal codes only force IDLE.

Test Plan:
- Reset=0 for 15 ns, then release with L=001 (green), default parameters -> timeout=0 during reset; single timeout pulse 4 cycles after first detection edge, then 0 while green persists for 20 further cycles.
- Sequence green→yellow (CAR-driven) 2 cycles after green detection -> no green pulse; timeout pulse exactly 2 cycles after yellow detection. Then red -> pulse 5 cycles after red detection.
- Red phase, hold=1 for 3 cycles in mid-count -> timeout pulse delayed to 8 cycles after red detection; timeout stays 0 while hold=1.
- L changes yellow→red on the same edge cnt reaches 0 in yellow -> no timeout pulse; red pulse 5 cycles later.
- Reset=0 asserted asynchronously mid-red with cnt=2 -> timeout=0 and state cleared immediately; after release with L=100 -> pulse 5 cycles after detection.
- (SEMAFORO_TIMER_FAULT_EN) L=110 for 1 cycle, then L=001 -> fault=1 from the next edge and stays 1; timer in IDLE during 110; green pulse 4 cycles after 001 detection; fault clears only on Reset=0.
